// File: rtl/tdm_demux.sv
// Serial TDM frame demultiplexer: assembles LSB-first WIDTH-bit words for N_CH channels per frame.
// Latency: out_valid one cycle after a word's last accepted bit; no backpressure, serial_valid gaps stall all state.
module tdm_demux #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    serial_valid,
  input  logic                    serial_data,
  input  logic                    frame_start,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [$clog2(N_CH)-1:0] out_ch,
  output logic                    frame_err
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(N_CH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_CH  = CW'(N_CH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t          state;
  logic [BW-1:0]   bit_cnt;
  logic [CW-1:0]   ch_cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word_nxt;
  logic [WIDTH-1:0] first_word;

  // Shift register with the incoming bit merged in at the current bit position.
  always_comb begin
    word_nxt          = shreg;
    word_nxt[bit_cnt] = serial_data;
    first_word        = '0;
    first_word[0]     = serial_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      ch_cnt    <= '0;
      shreg     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      frame_err <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      if (serial_valid) begin
        case (state)
          IDLE: begin
            if (frame_start) begin
              shreg   <= first_word;
              bit_cnt <= BW'(1);
              ch_cnt  <= '0;
              state   <= RECV;
            end
          end
          RECV: begin
            if (frame_start) begin
              // Resynchronise on the unexpected frame marker; the partial word is dropped.
              frame_err <= 1'b1;
              shreg     <= first_word;
              bit_cnt   <= BW'(1);
              ch_cnt    <= '0;
            end else if (bit_cnt == LAST_BIT) begin
              out_valid <= 1'b1;
              out_data  <= word_nxt;
              out_ch    <= ch_cnt;
              shreg     <= '0;
              bit_cnt   <= '0;
              if (ch_cnt == LAST_CH) begin
                ch_cnt <= '0;
                state  <= IDLE;
              end else begin
                ch_cnt <= ch_cnt + 1'b1;
              end
            end else begin
              shreg   <= word_nxt;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per channel word.
REQ-002 SHALL have parameter N_CH, default 4, channels per frame (power of two, >=2).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port serial_valid  input  1  serial_data is valid this cycle; a bit is accepted only when high.
REQ-006 SHALL have port serial_data  input  1  serial bit, LSB of each word first.
REQ-007 SHALL have port frame_start  input  1  qualifies the accepted bit as bit 0 of channel 0; ignored when serial_valid=0.
REQ-008 SHALL have port out_valid  output  1  one-cycle pulse, completed word present.
REQ-009 SHALL have port out_data  output  WIDTH  completed word.
REQ-010 SHALL have port out_ch  output  $clog2(N_CH)  channel index of out_data.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse, frame_start seen mid-frame.

Function
REQ-012 SHALL implement two states: IDLE (hunting for frame_start) and RECV (assembling frame).
REQ-013 SHALL keep bit counter (0..WIDTH-1), channel counter (0..N_CH-1) and WIDTH-bit shift register.
REQ-014 IDLE: accepted bit with frame_start=0 SHALL be discarded, no output activity.
REQ-015 IDLE: accepted bit with frame_start=1 SHALL be stored as bit 0 of channel 0, bit counter -> 1, state -> RECV.
REQ-016 RECV: each accepted bit with frame_start=0 SHALL be stored at position bit counter; bit counter increments.
REQ-017 Cycles with serial_valid=0 SHALL hold all state and counters (gaps of any length allowed).
REQ-018 On acceptance of bit WIDTH-1, SHALL assert out_valid in the next cycle for exactly one cycle, with out_data = assembled word and out_ch = channel counter value of that word.
REQ-019 After a completed word, bit counter SHALL wrap to 0 and channel counter SHALL increment.
REQ-020 On completion of channel N_CH-1, channel counter SHALL wrap to 0 and state -> IDLE.
REQ-021 RECV: accepted bit with frame_start=1 SHALL pulse frame_err next cycle for one cycle, discard partial word, and restart with that bit as bit 0 of channel 0 (bit counter -> 1, channel counter -> 0, stay RECV); no out_valid for the discarded word.
REQ-022 frame_start on the first accepted bit after frame end SHALL be normal operation (no frame_err), giving back-to-back frames with no idle cycle.
REQ-023 out_data and out_ch SHALL hold their last values between out_valid pulses.
REQ-024 Latency SHALL be exactly one cycle from acceptance of a word's last bit to out_valid.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 rst high SHALL immediately force state IDLE, counters 0, shift register 0, out_valid=0, out_data=0, out_ch=0, frame_err=0, independent of clk.
REQ-027 Reset mid-frame SHALL discard the partial frame; after release, block SHALL hunt for frame_start.

Verification (WIDTH=8, N_CH=4)
REQ-028 Contiguous frame ch0..3 = 0xA5,0x3C,0xFF,0x00, frame_start on bit 0 -> out_valid one cycle after bits 8,16,24,32 accepted; (out_ch,out_data) = (0,A5),(1,3C),(2,FF),(3,00); frame_err never high.
REQ-029 Same frame with serial_valid alternating 1/0 -> identical four words, each pulse one cycle after its last valid bit.
REQ-030 16 valid bits with frame_start=0 after reset -> no out_valid, no frame_err; out_data stays 0.
REQ-031 frame_start on accepted bit 13 of a frame (ch0=0x5A already emitted) -> frame_err pulse one cycle after bit 13; next 32 bits from that bit decode as ch0..3 with correct values.
REQ-032 rst asserted after 5 bits, released, then full frame 0x11,0x22,0x33,0x44 -> outputs 0 during reset, then four correct words on ch0..3.
REQ-033 Two back-to-back frames (second frame_start immediately after bit 32) -> eight out_valid pulses, out_ch 0,1,2,3,0,1,2,3, no frame_err.
